// File: rtl/keypad_bcd_encoder_pkg.sv
// Shared definitions for the keypad encoder: key codes, scan FSM states and
// the (row, column) to key-code mapping of the 4x3 front-panel keypad.
package keypad_pkg;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_START = 4'hB;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    // Rows 0-2 hold digits 1-9 left to right; row 3 is '*', '0', '#'.
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = KEY_CLEAR;
                2'd1:    code = 4'd0;
                default: code = KEY_START;
            endcase
        end else begin
            code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
        end
        return code;
    endfunction

    function automatic logic [2:0] col_drive(input logic [1:0] col);
        logic [2:0] drive;
        case (col)
            2'd0:    drive = 3'b110;
            2'd1:    drive = 3'b101;
            default: drive = 3'b011;
        endcase
        return drive;
    endfunction

    function automatic logic [1:0] col_inc(input logic [1:0] col);
        logic [1:0] nxt;
        case (col)
            2'd0:    nxt = 2'd1;
            2'd1:    nxt = 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/keypad_bcd_encoder_sync2.sv
// Parameterised-width two-flop synchronizer for bringing asynchronous
// inputs into the clk domain; RESET_VAL sets the idle level.
module sync2 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/keypad_bcd_encoder.sv
// Keypad scanner/encoder: drives one column low at a time, debounces a single
// pressed key and its release, and emits one BCD code per accepted press.
module keypad_bcd_encoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV         = 1000,
    parameter int DEBOUNCE_SAMPLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [2:0] col_n,
    output logic [3:0] bcd,
    output logic       key_valid,
    output logic       key_held,
    output logic       is_digit
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int MW = $clog2(DEBOUNCE_SAMPLES + 1);

    state_t          state_r, state_s;
    logic [1:0]      col_r, col_s;
    logic [2:0]      col_n_r;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [MW-1:0]   match_r, match_s;
    logic [MW-1:0]   rel_r, rel_s;
    logic [1:0]      cap_row_r, cap_row_s;
    logic [3:0]      bcd_r, bcd_s;
    logic            key_valid_r, key_valid_s;
    logic            key_held_r, key_held_s;
    logic            is_digit_r, is_digit_s;

    logic [3:0]      row_sync_s;
    logic            sample_s;
    logic            one_low_s;
    logic [1:0]      low_idx_s;
    logic [3:0]      cap_low_s;
    logic [3:0]      code_s;

    sync2 #(
        .WIDTH     (4),
        .RESET_VAL (4'hF)
    ) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row_n),
        .q     (row_sync_s)
    );

    // Row decode: a capture needs exactly one row low, anything else is ignored.
    always_comb begin
        one_low_s = 1'b1;
        low_idx_s = 2'd0;
        case (row_sync_s)
            4'b1110: low_idx_s = 2'd0;
            4'b1101: low_idx_s = 2'd1;
            4'b1011: low_idx_s = 2'd2;
            4'b0111: low_idx_s = 2'd3;
            default: one_low_s = 1'b0;
        endcase
    end

    assign sample_s  = (cnt_r == CW'(SCAN_DIV - 1));
    assign cap_low_s = 4'b0001 << cap_row_r;
    assign code_s    = key_code(cap_row_r, col_r);

    // Scan / debounce / held next-state and output logic.
    always_comb begin
        state_s     = state_r;
        col_s       = col_r;
        cnt_s       = sample_s ? '0 : cnt_r + CW'(1);
        match_s     = match_r;
        rel_s       = rel_r;
        cap_row_s   = cap_row_r;
        bcd_s       = bcd_r;
        is_digit_s  = is_digit_r;
        key_valid_s = 1'b0;
        key_held_s  = key_held_r;
        case (state_r)
            SCAN: begin
                if (sample_s && one_low_s) begin
                    state_s   = DEBOUNCE;
                    cap_row_s = low_idx_s;
                    match_s   = MW'(1);
                end else if (sample_s) begin
                    col_s = col_inc(col_r);
                end else begin
                    state_s = SCAN;
                end
            end
            DEBOUNCE: begin
                // Acceptance happens on the clock after the final matching sample.
                if (match_r == MW'(DEBOUNCE_SAMPLES)) begin
                    state_s     = HELD;
                    bcd_s       = code_s;
                    is_digit_s  = (code_s < 4'd10);
                    key_valid_s = 1'b1;
                    key_held_s  = 1'b1;
                    match_s     = '0;
                    rel_s       = '0;
                end else if (sample_s && (row_sync_s == ~cap_low_s)) begin
                    match_s = match_r + MW'(1);
                end else if (sample_s) begin
                    state_s = SCAN;
                    col_s   = col_inc(col_r);
                    match_s = '0;
                end else begin
                    state_s = DEBOUNCE;
                end
            end
            HELD: begin
                if (sample_s && row_sync_s[cap_row_r]) begin
                    if (rel_r == MW'(DEBOUNCE_SAMPLES - 1)) begin
                        state_s    = SCAN;
                        col_s      = col_inc(col_r);
                        key_held_s = 1'b0;
                        rel_s      = '0;
                    end else begin
                        rel_s = rel_r + MW'(1);
                    end
                end else if (sample_s) begin
                    rel_s = '0;
                end else begin
                    state_s = HELD;
                end
            end
            default: begin
                state_s    = SCAN;
                col_s      = 2'd0;
                match_s    = '0;
                rel_s      = '0;
                key_held_s = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= SCAN;
            col_r       <= 2'd0;
            col_n_r     <= 3'b110;
            cnt_r       <= '0;
            match_r     <= '0;
            rel_r       <= '0;
            cap_row_r   <= 2'd0;
            bcd_r       <= 4'd0;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
            is_digit_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            col_r       <= col_s;
            col_n_r     <= col_drive(col_s);
            cnt_r       <= cnt_s;
            match_r     <= match_s;
            rel_r       <= rel_s;
            cap_row_r   <= cap_row_s;
            bcd_r       <= bcd_s;
            key_valid_r <= key_valid_s;
            key_held_r  <= key_held_s;
            is_digit_r  <= is_digit_s;
        end
    end

    assign col_n     = col_n_r;
    assign bcd       = bcd_r;
    assign key_valid = key_valid_r;
    assign key_held  = key_held_r;
    assign is_digit  = is_digit_r;

endmodule

// File: tb/tb_keypad_bcd_encoder.sv
// Scoreboard bench for keypad_bcd_encoder (SCAN_DIV=4, DEBOUNCE_SAMPLES=3) with
// a behavioural keypad that pulls a row low when its pressed key's column is driven.
module tb_keypad_bcd_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row_n;
    logic [2:0]  col_n;
    logic [3:0]  bcd;
    logic        key_valid;
    logic        key_held;
    logic        is_digit;
    logic [11:0] pressed;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] code;
        logic       dig;
        int         at;
    } exp_t;
    exp_t sb[$];

    keypad_bcd_encoder #(
        .SCAN_DIV         (4),
        .DEBOUNCE_SAMPLES (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_n     (row_n),
        .col_n     (col_n),
        .bcd       (bcd),
        .key_valid (key_valid),
        .key_held  (key_held),
        .is_digit  (is_digit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Keypad matrix: key index = row*3 + col.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (pressed[r*3+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every key_valid pulse must match the oldest expected press.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && key_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_key_valid: got pulse with bcd=%0h, expected none (cycle %0d)", bcd, cyc);
            end else begin
                e = sb.pop_front();
                check("bcd", bcd, e.code);
                check("is_digit", is_digit, e.dig);
                check("key_held_at_valid", key_held, 1);
                if (e.at >= 0) check("press_latency", cyc, e.at);
            end
        end
    end

    task automatic wait_col(input logic [2:0] target);
        int n = 0;
        while (col_n == target && n < 40) begin @(negedge clk); n++; end
        while (col_n != target && n < 40) begin @(negedge clk); n++; end
        check("wait_col_in_time", (n < 40) ? 1 : 0, 1);
    endtask

    task automatic press(input int idx, input logic [2:0] colpat,
                         input logic [3:0] code, input logic dig);
        exp_t e;
        wait_col(colpat);
        e.code = code; e.dig = dig; e.at = cyc + 13;
        sb.push_back(e);
        pressed[idx] = 1'b1;
        repeat (20) @(negedge clk);
        pressed[idx] = 1'b0;
        repeat (20) @(negedge clk);
        check("released_key_held", key_held, 0);
    endtask

    initial begin
        int         base;
        int         t0;
        int         changes;
        logic [2:0] ex;
        logic [2:0] prev;
        exp_t       e;

        rst_n   = 1'b0;
        pressed = '0;
        repeat (3) @(negedge clk);
        check("rst_col_n", col_n, 3'b110);
        check("rst_bcd", bcd, 0);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_held", key_held, 0);
        check("rst_is_digit", is_digit, 0);

        // Idle scan: column walks 0,1,2 with a 4-clock dwell.
        rst_n = 1'b1;
        base  = cyc;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ex = 3'b001 << (((cyc - base) / 4) % 3);
            ex = ~ex;
            check("idle_col_n", col_n, ex);
        end
        check("idle_bcd", bcd, 0);

        // '5': exact latency, no auto-repeat, release debounce timing.
        wait_col(3'b101);
        t0 = cyc;
        e.code = 4'd5; e.dig = 1'b1; e.at = t0 + 13;
        sb.push_back(e);
        pressed[4] = 1'b1;
        repeat (12) @(negedge clk);
        check("held_before_accept", key_held, 0);
        @(negedge clk);
        check("held_after_accept", key_held, 1);
        repeat (47) @(negedge clk);
        check("held_col_frozen", col_n, 3'b101);
        pressed[4] = 1'b0;
        repeat (11) @(negedge clk);
        check("held_before_release_done", key_held, 1);
        @(negedge clk);
        check("held_cleared", key_held, 0);
        check("scan_resumed_col", col_n, 3'b011);
        check("bcd_kept_after_release", bcd, 5);
        repeat (10) @(negedge clk);

        press(11, 3'b011, 4'hB, 1'b0);
        press(10, 3'b101, 4'h0, 1'b1);

        // Bounce: '7' low for 5 clocks at a time cannot span three samples.
        for (int i = 0; i < 5; i++) begin
            pressed[6] = 1'b1;
            repeat (5) @(negedge clk);
            pressed[6] = 1'b0;
            repeat (15) @(negedge clk);
        end
        check("bounce_bcd", bcd, 0);
        check("bounce_is_digit", is_digit, 1);
        check("bounce_key_held", key_held, 0);

        // Ghost: rows 0 and 1 low on column 0 must not stop the scan.
        pressed[0] = 1'b1;
        pressed[3] = 1'b1;
        changes = 0;
        prev = col_n;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (col_n != prev) changes++;
            prev = col_n;
        end
        check("ghost_scan_continues", (changes >= 9) ? 1 : 0, 1);
        check("ghost_key_held", key_held, 0);
        pressed = '0;
        repeat (10) @(negedge clk);

        press(9, 3'b110, 4'hA, 1'b0);
        press(7, 3'b101, 4'h8, 1'b1);

        // Reset one sample before '3' would be accepted.
        wait_col(3'b011);
        pressed[2] = 1'b1;
        repeat (11) @(negedge clk);
        check("pre_reset_col_frozen", col_n, 3'b011);
        check("pre_reset_bcd", bcd, 8);
        rst_n = 1'b0;
        #1;
        check("midrst_col_n", col_n, 3'b110);
        check("midrst_bcd", bcd, 0);
        check("midrst_is_digit", is_digit, 0);
        check("midrst_key_held", key_held, 0);
        check("midrst_key_valid", key_valid, 0);
        pressed = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("post_reset_bcd", bcd, 0);
        check("post_reset_key_held", key_held, 0);

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no end of test, expected finish before 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
